// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the cpu-to-Avalon memory bridge.
// State encoding, MMIO register offsets and the timeout read value.
package mem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_DATA = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam logic [7:0]  OFF_LED      = 8'h00;
    localparam logic [7:0]  OFF_CNT      = 8'h02;
    localparam logic [7:0]  OFF_STAT     = 8'h04;
    localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

endpackage

// File: rtl/mmio_regs.sv
// Local MMIO register file: LED register, free-running cycle counter,
// sticky timeout status flag, with a combinational read mux.
module mmio_regs
    import mem_bridge_pkg::*;
#(
    parameter int LED_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_we,
    input  logic [7:0]       i_off,
    input  logic [15:0]      i_wdata,
    input  logic             i_to_set,
    output logic [15:0]      o_rdata,
    output logic [LED_W-1:0] o_led
);

    logic [LED_W-1:0] r_led;
    logic [15:0]      r_cnt;
    logic             r_to_flag;
    logic             w_unused;

    assign w_unused = ^i_wdata;
    assign o_led    = r_led;

    // LED register: only the low LED_W bits of a write are kept
    always_ff @(posedge clk) begin
        if (!reset)
            r_led <= '0;
        else if (i_we && i_off == OFF_LED)
            r_led <= i_wdata[LED_W-1:0];
    end

    // Cycle counter: increments every cycle, wraps naturally
    always_ff @(posedge clk) begin
        if (!reset)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 16'd1;
    end

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (!reset)
            r_to_flag <= 1'b0;
        else if (i_to_set)
            r_to_flag <= 1'b1;
    end

    // Read mux: unknown offsets read as zero
    always_comb begin
        o_rdata = '0;
        case (i_off)
            OFF_LED:  o_rdata[LED_W-1:0] = r_led;
            OFF_CNT:  o_rdata = r_cnt;
            OFF_STAT: o_rdata[0] = r_to_flag;
            default:  o_rdata = '0;
        endcase
    end

endmodule

// File: rtl/mem_bus_bridge.sv
// CPU single-cycle memory port to Avalon-MM master bridge with local MMIO.
// Optional read timeout enabled by defining MEM_BRIDGE_TIMEOUT_EN.
module mem_bus_bridge
    import mem_bridge_pkg::*;
#(
    parameter logic [15:0] MMIO_BASE = 16'hFF00,
    parameter int          LED_W     = 8,
    parameter int          TIMEOUT   = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      i_cpu_addr,
    input  logic             i_cpu_rd,
    input  logic             i_cpu_wr,
    input  logic [15:0]      i_cpu_wrdata,
    output logic [15:0]      o_cpu_rddata,
    output logic             o_cpu_stall,
    output logic [15:0]      o_avm_address,
    output logic             o_avm_read,
    output logic             o_avm_write,
    output logic [15:0]      o_avm_writedata,
    input  logic [15:0]      i_avm_readdata,
    input  logic             i_avm_readdatavalid,
    input  logic             i_avm_waitrequest,
    output logic [LED_W-1:0] o_led
);

    state_t      r_state;
    logic [15:0] r_addr;
    logic [15:0] r_data;
    logic        r_wr;
    logic [15:0] r_rddata;
    logic        r_avm_rd;
    logic        r_avm_wr;

    logic        w_req;
    logic        w_hit;
    logic        w_mmio_we;
    logic [15:0] w_mmio_rdata;
    logic        w_to_set;
    logic        w_unused;

    assign w_unused  = i_cpu_addr[0];
    assign w_req     = i_cpu_rd | i_cpu_wr;
    assign w_hit     = (i_cpu_addr[15:8] == MMIO_BASE[15:8]);
    assign w_mmio_we = (r_state == IDLE) && i_cpu_wr && w_hit;

`ifdef MEM_BRIDGE_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] r_to;
    assign w_to_set = (r_state == WAIT_DATA) && !i_avm_readdatavalid
                      && (r_to == TO_LAST);
`else
    assign w_to_set = 1'b0;
`endif

    assign o_cpu_stall     = ((r_state == IDLE) && w_req)
                             || (r_state == REQ)
                             || (r_state == WAIT_DATA);
    assign o_cpu_rddata    = r_rddata;
    assign o_avm_address   = r_addr;
    assign o_avm_writedata = r_data;
    assign o_avm_read      = r_avm_rd;
    assign o_avm_write     = r_avm_wr;

    mmio_regs #(
        .LED_W (LED_W)
    ) u_mmio (
        .clk      (clk),
        .reset    (reset),
        .i_we     (w_mmio_we),
        .i_off    ({i_cpu_addr[7:1], 1'b0}),
        .i_wdata  (i_cpu_wrdata),
        .i_to_set (w_to_set),
        .o_rdata  (w_mmio_rdata),
        .o_led    (o_led)
    );

    // Transaction FSM: MMIO answered from IDLE, Avalon via REQ/WAIT_DATA
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_data   <= '0;
            r_wr     <= 1'b0;
            r_rddata <= '0;
            r_avm_rd <= 1'b0;
            r_avm_wr <= 1'b0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
            r_to     <= '0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_addr <= {i_cpu_addr[15:1], 1'b0};
                        r_data <= i_cpu_wrdata;
                        r_wr   <= i_cpu_wr;
                        if (w_hit) begin
                            if (!i_cpu_wr)
                                r_rddata <= w_mmio_rdata;
                            r_state <= DONE;
                        end else begin
                            r_avm_rd <= ~i_cpu_wr;
                            r_avm_wr <= i_cpu_wr;
                            r_state  <= REQ;
                        end
                    end
                end
                REQ: begin
`ifdef MEM_BRIDGE_TIMEOUT_EN
                    r_to <= '0;
`endif
                    if (!i_avm_waitrequest) begin
                        r_avm_rd <= 1'b0;
                        r_avm_wr <= 1'b0;
                        r_state  <= r_wr ? DONE : WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (i_avm_readdatavalid) begin
                        r_rddata <= i_avm_readdata;
                        r_state  <= DONE;
                    end
`ifdef MEM_BRIDGE_TIMEOUT_EN
                    else if (r_to == TO_LAST) begin
                        r_rddata <= TIMEOUT_DATA;
                        r_state  <= DONE;
                    end else begin
                        r_to <= r_to + 16'd1;
                    end
`endif
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Self-checking bench for mem_bus_bridge: directed cases plus random
// cpu traffic against a behavioural model of memory, MMIO and latency.
module tb_mem_bus_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] i_cpu_addr;
    logic        i_cpu_rd;
    logic        i_cpu_wr;
    logic [15:0] i_cpu_wrdata;
    logic [15:0] o_cpu_rddata;
    logic        o_cpu_stall;
    logic [15:0] o_avm_address;
    logic        o_avm_read;
    logic        o_avm_write;
    logic [15:0] o_avm_writedata;
    logic [15:0] i_avm_readdata;
    logic        i_avm_readdatavalid;
    logic        i_avm_waitrequest;
    logic [7:0]  o_led;

    int n_chk  = 0;
    int n_fail = 0;

    // Slave memory (word indexed) and model state
    logic [15:0] mem [0:32767];
    logic [7:0]  m_led;
    logic [15:0] m_last;
    logic        m_flag;
    logic [15:0] tb_cyc;

    mem_bus_bridge dut (
        .clk                 (clk),
        .reset               (reset),
        .i_cpu_addr          (i_cpu_addr),
        .i_cpu_rd            (i_cpu_rd),
        .i_cpu_wr            (i_cpu_wr),
        .i_cpu_wrdata        (i_cpu_wrdata),
        .o_cpu_rddata        (o_cpu_rddata),
        .o_cpu_stall         (o_cpu_stall),
        .o_avm_address       (o_avm_address),
        .o_avm_read          (o_avm_read),
        .o_avm_write         (o_avm_write),
        .o_avm_writedata     (o_avm_writedata),
        .i_avm_readdata      (i_avm_readdata),
        .i_avm_readdatavalid (i_avm_readdatavalid),
        .i_avm_waitrequest   (i_avm_waitrequest),
        .o_led               (o_led)
    );

    always #5 clk = ~clk;

    // Cycles since reset release: what the MMIO counter should hold
    always @(posedge clk) begin
        if (!reset) tb_cyc = 16'd0;
        else        tb_cyc = tb_cyc + 16'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cpu access and act as the Avalon slave until completion.
    // lat = cycles from read acceptance to readdatavalid, 0 = never.
    task automatic access(input logic rd, input logic wr,
                          input logic [15:0] addr, input logic [15:0] data,
                          input int wn, input int lat, input bit spur,
                          output int stalls, output int nrd, output int nwr,
                          output logic [15:0] rdata,
                          output logic [15:0] baddr,
                          output logic [15:0] bwdata,
                          output bit ok);
        int wcnt;
        int pend;
        logic [15:0] raddr;
        bit done;
        i_cpu_rd = rd;
        i_cpu_wr = wr;
        i_cpu_addr = addr;
        i_cpu_wrdata = data;
        stalls = 0; nrd = 0; nwr = 0; wcnt = 0; pend = -1;
        done = 0; rdata = 'x; baddr = 'x; bwdata = 'x; raddr = '0;
        for (int c = 0; c < 1000 && !done; c++) begin
            #1;
            i_avm_readdatavalid = 1'b0;
            i_avm_waitrequest = 1'b0;
            i_avm_readdata = 16'h0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    i_avm_readdatavalid = 1'b1;
                    i_avm_readdata = mem[raddr[15:1]];
                    pend = -1;
                end
            end
            if (o_avm_read || o_avm_write) begin
                baddr = o_avm_address;
                if (wcnt < wn) begin
                    i_avm_waitrequest = 1'b1;
                    wcnt++;
                    if (spur) begin
                        i_avm_readdatavalid = 1'b1;
                        i_avm_readdata = 16'hBAD0;
                    end
                end else if (o_avm_write) begin
                    nwr++;
                    bwdata = o_avm_writedata;
                    mem[o_avm_address[15:1]] = o_avm_writedata;
                end else begin
                    nrd++;
                    raddr = o_avm_address;
                    pend = (lat == 0) ? -1 : lat;
                end
            end
            #1;
            if (o_cpu_stall) stalls++;
            else begin
                done = 1;
                rdata = o_cpu_rddata;
            end
            tick();
        end
        i_cpu_rd = 1'b0;
        i_cpu_wr = 1'b0;
        i_avm_readdatavalid = 1'b0;
        i_avm_waitrequest = 1'b0;
        ok = done;
    endtask

    // Model the expected outcome from the access rules, then compare
    task automatic txn(input string tag, input logic rd, input logic wr,
                       input logic [15:0] addr, input logic [15:0] data,
                       input int wn, input int lat, input bit spur);
        bit mmio;
        int e_st, e_rd, e_wr;
        logic [15:0] e_data;
        logic [6:0] off;
        int stalls, nrd, nwr;
        logic [15:0] rdata, baddr, bwdata;
        bit ok;
        mmio = (addr[15:8] == 8'hFF);
        off = addr[7:1];
        e_data = m_last;
        e_rd = 0;
        e_wr = 0;
        if (mmio) begin
            e_st = 1;
            if (wr) begin
                if (off == 7'd0) m_led = data[7:0];
            end else begin
                case (off)
                    7'd0:    e_data = {8'h00, m_led};
                    7'd1:    e_data = tb_cyc;
                    7'd2:    e_data = {15'd0, m_flag};
                    default: e_data = 16'h0000;
                endcase
            end
        end else if (wr) begin
            e_st = 2 + wn;
            e_wr = 1;
        end else begin
            e_wr = 0;
            e_rd = 1;
            if (lat == 0) begin
                e_st = 2 + wn + 255;
                e_data = 16'hDEAD;
                m_flag = 1'b1;
            end else begin
                e_st = 2 + wn + lat;
                e_data = mem[addr[15:1]];
            end
        end
        if (!wr) m_last = e_data;
        access(rd, wr, addr, data, wn, lat, spur,
               stalls, nrd, nwr, rdata, baddr, bwdata, ok);
        chk({tag, ".done"}, 32'(ok), 32'd1);
        chk({tag, ".stall"}, 32'(stalls), 32'(e_st));
        chk({tag, ".rddata"}, {16'h0, rdata}, {16'h0, e_data});
        chk({tag, ".nrd"}, 32'(nrd), 32'(e_rd));
        chk({tag, ".nwr"}, 32'(nwr), 32'(e_wr));
        chk({tag, ".led"}, {24'h0, o_led}, {24'h0, m_led});
        if (!mmio) begin
            chk({tag, ".addr"}, {16'h0, baddr}, {16'h0, addr & 16'hFFFE});
            if (wr) chk({tag, ".wdata"}, {16'h0, bwdata}, {16'h0, data});
        end
    endtask

    initial begin
        logic [15:0] c1;
        logic [15:0] a;
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        mem[16'h0010 >> 1] = 16'h1234;
        m_led = '0; m_last = '0; m_flag = 1'b0;
        reset = 1'b0;
        i_cpu_addr = '0; i_cpu_rd = 0; i_cpu_wr = 0; i_cpu_wrdata = '0;
        i_avm_readdata = '0; i_avm_readdatavalid = 0;
        i_avm_waitrequest = 0;
        tick(); tick();
        chk("rst.stall", 32'(o_cpu_stall), 32'd0);
        chk("rst.avm_rd", 32'(o_avm_read), 32'd0);
        chk("rst.avm_wr", 32'(o_avm_write), 32'd0);
        chk("rst.led", {24'h0, o_led}, 32'd0);
        chk("rst.rddata", {16'h0, o_cpu_rddata}, 32'd0);
        reset = 1'b1;
        tick();

        txn("rd0010", 1, 0, 16'h0010, 16'h0, 2, 1, 0);
        txn("rdwr0021", 1, 1, 16'h0021, 16'hBEEF, 0, 1, 0);
        chk("mem0020", {16'h0, mem[16'h0020 >> 1]}, 32'h0000BEEF);
        txn("ledwr", 0, 1, 16'hFF00, 16'h01A5, 0, 1, 0);
        txn("ledrd", 1, 0, 16'hFF00, 16'h0, 0, 1, 0);
        c1 = tb_cyc;
        txn("cnt1", 1, 0, 16'hFF02, 16'h0, 0, 1, 0);
        txn("cnt2", 1, 0, 16'hFF02, 16'h0, 0, 1, 0);
        chk("cnt.delta", {16'h0, m_last - c1}, 32'd2);
        txn("cntwr", 0, 1, 16'hFF03, 16'h5555, 0, 1, 0);
        txn("cnt3", 1, 0, 16'hFF02, 16'h0, 0, 1, 0);
        txn("stat", 1, 0, 16'hFF04, 16'h0, 0, 1, 0);
        txn("offwr", 0, 1, 16'hFF06, 16'h7777, 0, 1, 0);
        txn("offrd", 1, 0, 16'hFF06, 16'h0, 0, 1, 0);
        txn("topmmio", 1, 0, 16'hFFFE, 16'h0, 0, 1, 0);
        txn("belowmmio", 1, 0, 16'hFEFF, 16'h0, 1, 2, 0);
        txn("spur", 1, 0, 16'h0044, 16'h0, 3, 2, 1);

        // Reset while waiting for read data
        i_cpu_addr = 16'h0040; i_cpu_rd = 1'b1;
        tick();
        chk("wd.req", 32'(o_avm_read), 32'd1);
        tick();
        chk("wd.avm_rd", 32'(o_avm_read), 32'd0);
        chk("wd.stall", 32'(o_cpu_stall), 32'd1);
        reset = 1'b0; i_cpu_rd = 1'b0;
        tick();
        chk("wdrst.stall", 32'(o_cpu_stall), 32'd0);
        chk("wdrst.avm_rd", 32'(o_avm_read), 32'd0);
        chk("wdrst.led", {24'h0, o_led}, 32'd0);
        m_led = '0; m_last = '0; m_flag = 1'b0;
        reset = 1'b1;
        i_avm_readdatavalid = 1'b1; i_avm_readdata = 16'h7777;
        tick();
        i_avm_readdatavalid = 1'b0;
        tick();
        chk("late.stall", 32'(o_cpu_stall), 32'd0);
        chk("late.rddata", {16'h0, o_cpu_rddata}, 32'd0);

        // Random traffic over memory and the MMIO window
        for (int i = 0; i < 40; i++) begin
            logic rd, wr;
            int wn, lat;
            bit spur;
            case ($urandom_range(0, 2))
                0:       begin rd = 1; wr = 0; end
                1:       begin rd = 0; wr = 1; end
                default: begin rd = 1; wr = 1; end
            endcase
            if ($urandom_range(0, 2) == 0)
                a = 16'hFF00 | 16'($urandom_range(0, 15));
            else
                a = 16'($urandom_range(0, 255));
            wn = $urandom_range(0, 3);
            lat = $urandom_range(1, 3);
            spur = ($urandom_range(0, 1) == 1);
            txn($sformatf("rnd%0d", i), rd, wr, a, 16'($urandom),
                wn, lat, spur);
        end

`ifdef MEM_BRIDGE_TIMEOUT_EN
        txn("tmo", 1, 0, 16'h0080, 16'h0, 1, 0, 0);
        txn("tmostat", 1, 0, 16'hFF04, 16'h0, 0, 1, 0);
        txn("posttmo", 1, 0, 16'h0082, 16'h0, 0, 1, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
